// File: rtl/sm2_pkg.sv
// rtl/sm2_pkg.sv - shared widths, beat-count helper and FSM encoding for the SM2 ciphertext streamer
package sm2_pkg;

  localparam int C1_W   = 512;
  localparam int C3_W   = 256;
  localparam int BEAT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } ct_state_t;

  // Beats per frame for a given C2 length, rounding the tail beat up.
  function automatic int ct_beats(input int len_m);
    return (len_m + C1_W + C3_W + BEAT_W - 1) / BEAT_W;
  endfunction

endpackage

// File: rtl/sm2_ct_reorder.sv
// rtl/sm2_ct_reorder.sv - combinational field permutation and LSB zero-padding of the ciphertext frame
module sm2_ct_reorder
  import sm2_pkg::*;
#(
  parameter int len_M        = 152,
  parameter bit ORDER_C1C2C3 = 1'b0,
  localparam int W           = len_M + C1_W + C3_W,
  localparam int FW          = BEAT_W * ct_beats(len_M)
) (
  input  logic [W-1:0]  in_data,
  output logic [FW-1:0] frame
);

  localparam int PAD = FW - W;

  logic [W-1:0] ordered;

  generate
    if (ORDER_C1C2C3) begin : g_c1c2c3
      assign ordered = {in_data[W-1 -: C1_W], in_data[len_M-1:0], in_data[W-C1_W-1 -: C3_W]};
    end else begin : g_c1c3c2
      assign ordered = in_data;
    end
  endgenerate

  // Left-align so the final beat carries its zero padding at the bottom.
  assign frame = FW'(ordered) << PAD;

endmodule

// File: rtl/sm2_ct_streamer.sv
// rtl/sm2_ct_streamer.sv - captures the SM2 ciphertext on done and streams it as 32-bit valid/ready beats
module sm2_ct_streamer
  import sm2_pkg::*;
#(
  parameter int len_M        = 152,
  parameter bit ORDER_C1C2C3 = 1'b0,
  localparam int W           = len_M + C1_W + C3_W,
  localparam int NW          = ct_beats(len_M)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      in_data,
  input  logic              in_done,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int FW = NW * BEAT_W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

  ct_state_t     state;
  logic          done_q;
  logic          start;
  logic [FW-1:0] shreg;
  logic [FW-1:0] frame;
  logic [CW-1:0] count;

  sm2_ct_reorder #(
    .len_M        (len_M),
    .ORDER_C1C2C3 (ORDER_C1C2C3)
  ) u_reorder (
    .in_data (in_data),
    .frame   (frame)
  );

  assign start    = in_done && !done_q;
  assign out_data = shreg[FW-1 -: BEAT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      shreg      <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      done_q     <= in_done;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg     <= frame;
            count     <= '0;
            out_valid <= 1'b1;
            out_last  <= (NW == 1);
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            shreg <= shreg << BEAT_W;
            if (count == LAST_IDX) begin
              count      <= '0;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= HOLD;
            end else begin
              count    <= count + CW'(1);
              out_last <= ((count + CW'(1)) == LAST_IDX);
            end
          end
        end
        // A done level that never drops must not retrigger a frame.
        HOLD: begin
          if (!in_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm2_ct_streamer.sv
// tb/tb_sm2_ct_streamer.sv - directed self-checking bench for sm2_ct_streamer in both field orders
module tb_sm2_ct_streamer;

  localparam int W  = 920;
  localparam int NW = 29;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b1;
  logic in_done0 = 1'b0;
  logic in_done1 = 1'b0;
  logic sel = 1'b0;
  logic [W-1:0] in_data0, in_data1;
  logic [31:0] out_data0, out_data1;
  logic out_valid0, out_last0, busy0, frame_done0;
  logic out_valid1, out_last1, busy1, frame_done1;
  logic [31:0] m_data;
  logic m_valid, m_last, m_busy, m_fd;

  always #5 clk = ~clk;

  sm2_ct_streamer #(.len_M(152), .ORDER_C1C2C3(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_done(in_done0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_last(out_last0), .busy(busy0), .frame_done(frame_done0));

  sm2_ct_streamer #(.len_M(152), .ORDER_C1C2C3(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_done(in_done1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_last(out_last1), .busy(busy1), .frame_done(frame_done1));

  assign m_data  = sel ? out_data1  : out_data0;
  assign m_valid = sel ? out_valid1 : out_valid0;
  assign m_last  = sel ? out_last1  : out_last0;
  assign m_busy  = sel ? busy1      : busy0;
  assign m_fd    = sel ? frame_done1 : frame_done0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp0 [NW];
  logic [31:0] exp1 [NW];
  logic [31:0] got [NW];
  logic        got_last [NW];
  int acc, busy_cyc, stab_err, cycles;

  // Collects one frame from the selected DUT; bp toggles ready 1,0,1,0; inject pulses in_done0 low mid-frame.
  task automatic run_frame(input bit bp, input bit inject);
    logic [31:0] hd;
    logic hl;
    bit holding;
    acc = 0; busy_cyc = 0; stab_err = 0; cycles = 0; holding = 0; hd = '0; hl = 1'b0;
    while (acc < NW && cycles < 300) begin
      out_ready = bp ? (cycles % 2 == 0) : 1'b1;
      if (inject && cycles == 5) in_done0 = 1'b0;
      if (inject && cycles == 6) in_done0 = 1'b1;
      if (m_busy) busy_cyc++;
      if (holding && (m_data !== hd || m_last !== hl)) stab_err++;
      holding = 0;
      if (m_valid) begin
        if (out_ready) begin
          got[acc] = m_data; got_last[acc] = m_last; acc++;
        end else begin
          holding = 1; hd = m_data; hl = m_last;
        end
      end
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({out_data0, out_valid0, out_last0, busy0, frame_done0} !== 36'h0) begin
      n_err++; $display("FAIL reset_dut0 got %h want 0", {out_data0, out_valid0, out_last0, busy0, frame_done0});
    end
    n_cmp++;
    if ({out_data1, out_valid1, out_last1, busy1, frame_done1} !== 36'h0) begin
      n_err++; $display("FAIL reset_dut1 got %h want 0", {out_data1, out_valid1, out_last1, busy1, frame_done1});
    end
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b want 0", out_valid0); end
  endtask

  task automatic check_frame(input string name, input bit use1);
    n_cmp++;
    if (acc !== NW) begin n_err++; $display("FAIL %s_beat_count got %0d want %0d", name, acc, NW); end
    for (int i = 0; i < NW; i++) begin
      if (i < acc) begin
        n_cmp++;
        if (got[i] !== (use1 ? exp1[i] : exp0[i])) begin
          n_err++; $display("FAIL %s_beat%0d got %h want %h", name, i, got[i], use1 ? exp1[i] : exp0[i]);
        end
        n_cmp++;
        if (got_last[i] !== (i == NW - 1)) begin
          n_err++; $display("FAIL %s_last%0d got %b want %b", name, i, got_last[i], i == NW - 1);
        end
      end
    end
    n_cmp++;
    if ({m_fd, m_valid, m_busy} !== 3'b100) begin
      n_err++; $display("FAIL %s_post_frame fd/valid/busy got %b want 100", name, {m_fd, m_valid, m_busy});
    end
    @(negedge clk);
    n_cmp++;
    if (m_fd !== 1'b0) begin n_err++; $display("FAIL %s_fd_pulse got %b want 0", name, m_fd); end
  endtask

  task automatic test_basic;
    sel = 1'b0;
    in_done0 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid0, busy0} !== 2'b11) begin n_err++; $display("FAIL basic_latency got %b want 11", {out_valid0, busy0}); end
    run_frame(1'b0, 1'b0);
    n_cmp++;
    if (cycles !== NW) begin n_err++; $display("FAIL basic_cycles got %0d want %0d", cycles, NW); end
    n_cmp++;
    if (busy_cyc !== NW) begin n_err++; $display("FAIL basic_busy got %0d want %0d", busy_cyc, NW); end
    check_frame("basic", 1'b0);
  endtask

  task automatic test_level_hold;
    int v;
    v = 0;
    repeat (100) begin
      if (out_valid0 || busy0) v++;
      @(negedge clk);
    end
    n_cmp++;
    if (v !== 0) begin n_err++; $display("FAIL level_hold got %0d active cycles want 0", v); end
  endtask

  task automatic test_backpressure;
    sel = 1'b0;
    in_done0 = 1'b0;
    @(negedge clk);
    in_done0 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b1) begin n_err++; $display("FAIL bp_start got %b want 1", out_valid0); end
    run_frame(1'b1, 1'b0);
    n_cmp++;
    if (stab_err !== 0) begin n_err++; $display("FAIL bp_stability got %0d unstable want 0", stab_err); end
    check_frame("bp", 1'b0);
  endtask

  task automatic test_rearm;
    int v;
    sel = 1'b0;
    in_done0 = 1'b0;
    @(negedge clk);
    in_done0 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b1) begin n_err++; $display("FAIL rearm_start got %b want 1", out_valid0); end
    run_frame(1'b0, 1'b1);
    check_frame("rearm", 1'b0);
    v = 0;
    repeat (30) begin
      if (out_valid0) v++;
      @(negedge clk);
    end
    n_cmp++;
    if (v !== 0) begin n_err++; $display("FAIL rearm_no_retx got %0d valid cycles want 0", v); end
    in_done0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reorder;
    sel = 1'b1;
    in_done1 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL reorder_start got %b want 1", out_valid1); end
    run_frame(1'b0, 1'b0);
    check_frame("reorder", 1'b1);
    in_done1 = 1'b0;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    int v;
    sel = 1'b0;
    in_done0 = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (out_data0 !== exp0[10]) begin n_err++; $display("FAIL rst_at_beat10 got %h want %h", out_data0, exp0[10]); end
    rst_n = 1'b0;
    in_done0 = 1'b0;
    #1;
    n_cmp++;
    if ({out_data0, out_valid0, out_last0, busy0} !== 35'h0) begin
      n_err++; $display("FAIL rst_async got %h want 0", {out_data0, out_valid0, out_last0, busy0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = 0;
    repeat (20) begin
      if (out_valid0) v++;
      @(negedge clk);
    end
    n_cmp++;
    if (v !== 0) begin n_err++; $display("FAIL rst_no_resume got %0d valid cycles want 0", v); end
    in_done0 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b1) begin n_err++; $display("FAIL rst_restart got %b want 1", out_valid0); end
    run_frame(1'b0, 1'b0);
    check_frame("rst_restart", 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      exp0[i] = (i == 0) ? 32'hDEADBEEF : (i == NW - 1) ? 32'hABCDEF00 : 32'h01000000 + i;
      if (i < 16) exp1[i] = 32'h55555555;
      else if (i < 20) exp1[i] = 32'h22222222;
      else if (i == 20) exp1[i] = 32'h22222211;
      else if (i < 28) exp1[i] = 32'h11111111;
      else exp1[i] = 32'h11111100;
    end
    in_data0 = '0;
    for (int i = 0; i < NW - 1; i++) in_data0[W-1-32*i -: 32] = exp0[i];
    in_data0[23:0] = 24'hABCDEF;
    in_data1 = {{64{8'h55}}, {32{8'h11}}, {19{8'h22}}};

    test_reset();
    test_basic();
    test_level_hold();
    test_backpressure();
    test_rearm();
    test_reorder();
    test_reset_mid_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
